// File: rtl/router_pkg.sv
// Field positions within a router packet, plus the virtual-channel id type.
// Shared by the router, the output channels and the output arbiters.
package router_pkg;

    localparam int VC_BIT          = 63;
    localparam int NORTH_SOUTH_BIT = 62;
    localparam int EAST_WEST_BIT   = 61;
    localparam int HOP_BIT_WIDTH   = 8;
    localparam int Y_HOP_BIT       = 53;
    localparam int X_HOP_BIT       = 45;

    typedef enum logic {
        VC0 = 1'b0,
        VC1 = 1'b1
    } vc_e;

endpackage

// File: rtl/router_output_arbiter_picker.sv
// Combinational round-robin search.
// Returns the first set bit of elig at or after ptr, wrapping around.
module router_rr_picker
    import router_pkg::*;
#(
    parameter  int NUM_REQ = 4,
    localparam int PTR_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] elig,
    input  logic [PTR_W-1:0]   ptr,
    output logic               found,
    output logic [PTR_W-1:0]   idx
);

    logic [PTR_W-1:0] cand;

    // Scan offsets from farthest to nearest so the nearest hit is written last.
    always_comb begin
        found = 1'b0;
        idx   = '0;
        cand  = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            cand = PTR_W'((int'(ptr) + k) % NUM_REQ);
            if (elig[cand]) begin
                found = 1'b1;
                idx   = cand;
            end
        end
    end

endmodule

// File: rtl/router_output_arbiter.sv
// Round-robin arbiter and registered mux feeding one router output channel.
// Arbitrates per virtual channel and holds the winning packet while the output is blocked.
module router_output_arbiter #(
    parameter  int NUM_REQ = 4,
    parameter  int DATA_W  = 64,
    parameter  int VC_BIT  = router_pkg::VC_BIT,
    localparam int PTR_W   = $clog2(NUM_REQ)
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      polarity,
    input  logic [NUM_REQ-1:0]        req,
    input  logic [NUM_REQ*DATA_W-1:0] data_in,
    input  logic                      out_blocked,
    output logic [NUM_REQ-1:0]        grant,
    output logic [NUM_REQ-1:0]        consumed,
    output logic                      out_valid,
    output logic [DATA_W-1:0]         data_out
);

    import router_pkg::*;

    logic [NUM_REQ-1:0] elig;
    logic [PTR_W-1:0]   ptr_vc0;
    logic [PTR_W-1:0]   ptr_vc1;
    logic [PTR_W-1:0]   cur_ptr;
    logic [PTR_W-1:0]   next_ptr;
    logic [PTR_W-1:0]   win_idx;
    logic [NUM_REQ-1:0] win_onehot;
    logic [DATA_W-1:0]  win_data;
    logic               found;
    logic               load;
    vc_e                cur_vc;

    // Only requests whose packet belongs to the VC selected by polarity compete.
    for (genvar g = 0; g < NUM_REQ; g++) begin : g_elig
        assign elig[g] = req[g] && (data_in[g*DATA_W + VC_BIT] == polarity);
    end

    assign cur_vc  = vc_e'(polarity);
    assign cur_ptr = (cur_vc == VC1) ? ptr_vc1 : ptr_vc0;
    assign load    = !out_valid || !out_blocked;

    router_rr_picker #(
        .NUM_REQ (NUM_REQ)
    ) u_picker (
        .elig  (elig),
        .ptr   (cur_ptr),
        .found (found),
        .idx   (win_idx)
    );

    assign next_ptr   = (win_idx == PTR_W'(NUM_REQ - 1)) ? '0 : win_idx + 1'b1;
    assign win_onehot = NUM_REQ'(1) << win_idx;

    always_comb begin
        win_data = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (win_idx == PTR_W'(i)) begin
                win_data = data_in[i*DATA_W +: DATA_W];
            end
        end
    end

    // consumed is a single-cycle pulse; everything else holds unless a load happens.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            grant     <= '0;
            consumed  <= '0;
            out_valid <= 1'b0;
            data_out  <= '0;
            ptr_vc0   <= '0;
            ptr_vc1   <= '0;
        end else begin
            consumed <= '0;
            if (load) begin
                if (found) begin
                    data_out  <= win_data;
                    out_valid <= 1'b1;
                    grant     <= win_onehot;
                    consumed  <= win_onehot;
                    if (cur_vc == VC1) begin
                        ptr_vc1 <= next_ptr;
                    end else begin
                        ptr_vc0 <= next_ptr;
                    end
                end else begin
                    out_valid <= 1'b0;
                    grant     <= '0;
                end
            end
        end
    end

endmodule

// File: tb/tb_router_output_arbiter.sv
// Bench for router_output_arbiter: directed vector table, async reset check,
// and a randomized run against a queue-level requester/arbiter model.
module tb_router_output_arbiter;

    localparam int N = 4;
    localparam int W = 64;

    logic           clk = 1'b0;
    logic           reset;
    logic           polarity;
    logic           out_blocked;
    logic [N-1:0]   req;
    logic [N*W-1:0] data_in;
    logic [N-1:0]   grant;
    logic [N-1:0]   consumed;
    logic           out_valid;
    logic [W-1:0]   data_out;

    int n_compared   = 0;
    int n_mismatched = 0;

    typedef struct {
        logic [N-1:0] req;
        logic [N-1:0] vc;
        logic         pol;
        logic         blk;
        logic         exp_valid;
        logic [N-1:0] exp_grant;
        logic [N-1:0] exp_cons;
    } vec_t;

    vec_t vecs[23];

    // Random-phase requester and arbiter model state.
    logic         pending[N];
    logic         pvc[N];
    int           pseq[N];
    int           wait_cnt[N];
    int           seq;
    int           ptr_m[2];
    logic         m_valid;
    logic         m_load;
    logic [N-1:0] m_grant;
    logic [N-1:0] m_cons;
    logic [W-1:0] m_data;
    int           win;

    router_output_arbiter #(
        .NUM_REQ (N),
        .DATA_W  (W),
        .VC_BIT  (63)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .polarity    (polarity),
        .req         (req),
        .data_in     (data_in),
        .out_blocked (out_blocked),
        .grant       (grant),
        .consumed    (consumed),
        .out_valid   (out_valid),
        .data_out    (data_out)
    );

    always #5 clk = ~clk;

    function automatic logic [W-1:0] mk_pkt(input int i, input logic vc, input int tag);
        logic [31:0] t;
        logic [31:0] idx;
        t   = tag;
        idx = i;
        return {vc, t[30:0], idx};
    endfunction

    task automatic checkOutput(input string name, input logic [95:0] actual, input logic [95:0] expected);
        n_compared++;
        if (actual !== expected) begin
            n_mismatched++;
            $display("[TB] FAIL %s: actual=%h required=%h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic [N-1:0] r, input logic [N-1:0] vcs,
                                 input logic pol, input logic blk, input int tag);
        req         = r;
        polarity    = pol;
        out_blocked = blk;
        for (int i = 0; i < N; i++) begin
            data_in[i*W +: W] = mk_pkt(i, vcs[i], tag);
        end
    endtask

    initial begin
        logic [W-1:0] exp_data;

        // Fairness, backpressure, VC isolation, wrap and blocked-while-empty cases.
        vecs[0]  = '{4'b1111, 4'b0000, 1'b0, 1'b0, 1'b1, 4'b0001, 4'b0001};
        vecs[1]  = '{4'b1111, 4'b0000, 1'b1, 1'b0, 1'b0, 4'b0000, 4'b0000};
        vecs[2]  = '{4'b1111, 4'b0000, 1'b0, 1'b0, 1'b1, 4'b0010, 4'b0010};
        vecs[3]  = '{4'b1111, 4'b0000, 1'b1, 1'b0, 1'b0, 4'b0000, 4'b0000};
        vecs[4]  = '{4'b1111, 4'b0000, 1'b0, 1'b0, 1'b1, 4'b0100, 4'b0100};
        vecs[5]  = '{4'b1111, 4'b0000, 1'b1, 1'b0, 1'b0, 4'b0000, 4'b0000};
        vecs[6]  = '{4'b1111, 4'b0000, 1'b0, 1'b0, 1'b1, 4'b1000, 4'b1000};
        vecs[7]  = '{4'b1111, 4'b0000, 1'b1, 1'b0, 1'b0, 4'b0000, 4'b0000};
        vecs[8]  = '{4'b1111, 4'b0000, 1'b0, 1'b0, 1'b1, 4'b0001, 4'b0001};
        vecs[9]  = '{4'b1111, 4'b0000, 1'b0, 1'b0, 1'b1, 4'b0010, 4'b0010};
        vecs[10] = '{4'b1111, 4'b0000, 1'b0, 1'b1, 1'b1, 4'b0010, 4'b0000};
        vecs[11] = '{4'b1111, 4'b0000, 1'b0, 1'b1, 1'b1, 4'b0010, 4'b0000};
        vecs[12] = '{4'b1111, 4'b0000, 1'b0, 1'b1, 1'b1, 4'b0010, 4'b0000};
        vecs[13] = '{4'b1111, 4'b0000, 1'b0, 1'b0, 1'b1, 4'b0100, 4'b0100};
        vecs[14] = '{4'b0101, 4'b0001, 1'b0, 1'b0, 1'b1, 4'b0100, 4'b0100};
        vecs[15] = '{4'b0101, 4'b0001, 1'b1, 1'b0, 1'b1, 4'b0001, 4'b0001};
        vecs[16] = '{4'b0101, 4'b0001, 1'b0, 1'b0, 1'b1, 4'b0100, 4'b0100};
        vecs[17] = '{4'b0101, 4'b0001, 1'b1, 1'b0, 1'b1, 4'b0001, 4'b0001};
        vecs[18] = '{4'b0011, 4'b0000, 1'b0, 1'b0, 1'b1, 4'b0001, 4'b0001};
        vecs[19] = '{4'b1010, 4'b0000, 1'b0, 1'b0, 1'b1, 4'b0010, 4'b0010};
        vecs[20] = '{4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0, 4'b0000, 4'b0000};
        vecs[21] = '{4'b0001, 4'b0000, 1'b0, 1'b1, 1'b1, 4'b0001, 4'b0001};
        vecs[22] = '{4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0, 4'b0000, 4'b0000};

        reset       = 1'b1;
        req         = '0;
        polarity    = 1'b0;
        out_blocked = 1'b0;
        data_in     = '0;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset_state", {out_valid, grant, consumed, data_out}, 96'd0);
        reset = 1'b0;

        exp_data = '0;
        for (int s = 0; s < 23; s++) begin
            applyStimulus(vecs[s].req, vecs[s].vc, vecs[s].pol, vecs[s].blk, s);
            @(posedge clk);
            #1;
            for (int i = 0; i < N; i++) begin
                if (vecs[s].exp_cons[i]) exp_data = mk_pkt(i, vecs[s].vc[i], s);
            end
            checkOutput($sformatf("vec%0d", s), {out_valid, grant, consumed, data_out},
                        {vecs[s].exp_valid, vecs[s].exp_grant, vecs[s].exp_cons, exp_data});
        end

        // Asynchronous reset while a packet is held against backpressure.
        applyStimulus(4'b0001, 4'b0000, 1'b0, 1'b0, 100);
        @(posedge clk);
        #1;
        applyStimulus(4'b0000, 4'b0000, 1'b0, 1'b1, 101);
        @(posedge clk);
        #1;
        checkOutput("hold_before_reset", {out_valid, grant, consumed, data_out},
                    {1'b1, 4'b0001, 4'b0000, mk_pkt(0, 1'b0, 100)});
        #2;
        reset = 1'b1;
        #1;
        checkOutput("reset_async", {out_valid, grant, consumed, data_out}, 96'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;

        // Both pointers were non-zero before the reset; they must now start at 0.
        applyStimulus(4'b1111, 4'b0000, 1'b0, 1'b0, 102);
        @(posedge clk);
        #1;
        checkOutput("ptr0_after_reset", {out_valid, grant, consumed}, {1'b1, 4'b0001, 4'b0001});
        applyStimulus(4'b1111, 4'b1111, 1'b1, 1'b0, 103);
        @(posedge clk);
        #1;
        checkOutput("ptr1_after_reset", {out_valid, grant, consumed}, {1'b1, 4'b0001, 4'b0001});

        reset = 1'b1;
        req   = '0;
        @(posedge clk);
        #1;
        reset = 1'b0;

        for (int i = 0; i < N; i++) begin
            pending[i]  = 1'b0;
            pvc[i]      = 1'b0;
            pseq[i]     = 0;
            wait_cnt[i] = 0;
        end
        seq      = 1;
        ptr_m[0] = 0;
        ptr_m[1] = 0;
        m_valid  = 1'b0;
        m_grant  = '0;
        m_cons   = '0;
        m_data   = '0;

        for (int c = 0; c < 10000; c++) begin
            for (int i = 0; i < N; i++) begin
                if (!pending[i] && $urandom_range(0, 99) < 40) begin
                    pending[i]  = 1'b1;
                    pvc[i]      = 1'($urandom_range(0, 1));
                    pseq[i]     = seq;
                    wait_cnt[i] = 0;
                    seq++;
                end
                req[i] = pending[i];
                if (pending[i]) data_in[i*W +: W] = mk_pkt(i, pvc[i], pseq[i]);
                else            data_in[i*W +: W] = {$urandom(), $urandom()};
            end
            polarity    = 1'($urandom_range(0, 1));
            out_blocked = ($urandom_range(0, 99) < 30);

            // Expected result of this edge from the requester queues.
            m_load = !m_valid || !out_blocked;
            m_cons = '0;
            win    = -1;
            if (m_load) begin
                for (int k = 0; k < N; k++) begin
                    int j;
                    j = (ptr_m[polarity] + k) % N;
                    if (win < 0 && pending[j] && pvc[j] == polarity) win = j;
                end
                if (win >= 0) begin
                    m_valid         = 1'b1;
                    m_grant         = N'(1) << win;
                    m_cons          = m_grant;
                    m_data          = mk_pkt(win, pvc[win], pseq[win]);
                    ptr_m[polarity] = (win + 1) % N;
                end else begin
                    m_valid = 1'b0;
                    m_grant = '0;
                end
            end

            @(posedge clk);
            #1;
            checkOutput("rand_out", {out_valid, grant, consumed, data_out},
                        {m_valid, m_grant, m_cons, m_data});
            checkOutput("onehot_grant", 96'($onehot0(grant)), 96'd1);
            checkOutput("onehot_consumed", 96'($onehot0(consumed)), 96'd1);
            checkOutput("grant_iff_valid", 96'((grant != '0) == out_valid), 96'd1);

            if (consumed != '0) begin
                for (int i = 0; i < N; i++) begin
                    if (pending[i] && pvc[i] == polarity) begin
                        if (consumed[i]) begin
                            checkOutput($sformatf("rr_wait%0d", i), 96'(wait_cnt[i] <= N - 1), 96'd1);
                            wait_cnt[i] = 0;
                        end else begin
                            wait_cnt[i]++;
                        end
                    end
                end
            end
            if (win >= 0) pending[win] = 1'b0;
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
